// File: rtl/axi_scb_pkg.sv
// rtl/axi_scb_pkg.sv - shared types and helpers for the AXI beat scoreboard
package axi_scb_pkg;

  // Ordering model: one global queue, or one queue per AXI ID
  typedef enum logic {
    SCB_GLOBAL = 1'b0,
    SCB_PER_ID = 1'b1
  } scb_order_e;

  // Widest statistics counter the helper below can serve
  localparam int unsigned SAT_MAX_W = 32;

  // Add one to a cnt_w-bit counter carried in a 32-bit container; all-ones holds
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] val,
                                                   input int unsigned cnt_w);
    logic [SAT_MAX_W-1:0] ones;
    ones = (cnt_w >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << cnt_w) - SAT_MAX_W'(1));
    return (val >= ones) ? ones : val + SAT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/axi_scb_fifo.sv
// rtl/axi_scb_fifo.sv - synchronous beat FIFO with flush and wrap-bit full/empty
module axi_scb_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];

  // Pointers differ only in the wrap bit when every slot holds a beat
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer next-state: flush wins, otherwise guarded push and pop advance independently
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push && !full) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop && !empty) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end
  end

  // Pointer registers; storage contents need no reset because empty masks them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Beat storage write port
  always_ff @(posedge clk) begin
    if (push && !full && !flush) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/axi_beat_scoreboard.sv
// rtl/axi_beat_scoreboard.sv - in-order AXI beat scoreboard with per-ID queues and stall watchdog
module axi_beat_scoreboard
  import axi_scb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024,
  parameter int PER_ID  = 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              clear,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [ID_W-1:0]   exp_id,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              exp_last,
  input  logic              act_valid,
  output logic              act_ready,
  input  logic [ID_W-1:0]   act_id,
  input  logic [DATA_W-1:0] act_data,
  input  logic              act_last,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  timeout_cnt,
  output logic              mismatch,
  output logic [ID_W-1:0]   mismatch_id,
  output logic              timeout,
  output logic              idle
);

  localparam scb_order_e ORDER = (PER_ID != 0) ? SCB_PER_ID : SCB_GLOBAL;
  localparam int NUM_Q = (ORDER == SCB_PER_ID) ? (1 << ID_W) : 1;
  // In global order the ID travels with the beat so a mis-routed beat still mismatches
  localparam int ENT_W = (ORDER == SCB_PER_ID) ? DATA_W + 1 : ID_W + DATA_W + 1;
  localparam int SW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STALL_LAST = SW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [SW-1:0] STALL_ONE  = 1;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    logic [SAT_MAX_W-1:0] w;
    w = sat_inc(SAT_MAX_W'(v), CNT_W);
    return w[CNT_W-1:0];
  endfunction

  logic [ID_W-1:0]  exp_q, act_q;
  logic [ENT_W-1:0] exp_ent, act_ent;
  logic [NUM_Q-1:0] q_full, q_empty, q_push, q_pop;
  logic [ENT_W-1:0] q_head [NUM_Q];

  logic             exp_full_sel, act_empty_sel, act_flag_sel;
  logic [ENT_W-1:0] head_sel;
  logic             exp_acc, act_acc, beat_mis;

  logic [NUM_Q-1:0] err_flag_q, err_flag_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;
  logic             mismatch_q, mismatch_d;
  logic [ID_W-1:0]  mismatch_id_q, mismatch_id_d;
  logic             timeout_q, timeout_d;
  logic [SW-1:0]    stall_q, stall_d;

  assign exp_q = (ORDER == SCB_PER_ID) ? exp_id : '0;
  assign act_q = (ORDER == SCB_PER_ID) ? act_id : '0;

  if (ORDER == SCB_PER_ID) begin : g_ent_per_id
    assign exp_ent = {exp_data, exp_last};
    assign act_ent = {act_data, act_last};
  end else begin : g_ent_global
    assign exp_ent = {exp_id, exp_data, exp_last};
    assign act_ent = {act_id, act_data, act_last};
  end

  for (genvar i = 0; i < NUM_Q; i++) begin : g_q
    assign q_push[i] = exp_acc && (exp_q == ID_W'(i));
    assign q_pop[i]  = act_acc && (act_q == ID_W'(i));

    axi_scb_fifo #(
      .DEPTH (DEPTH),
      .W     (ENT_W)
    ) u_fifo (
      .clk       (aclk),
      .rst_n     (aresetn),
      .flush     (clear),
      .push      (q_push[i]),
      .push_data (exp_ent),
      .pop       (q_pop[i]),
      .head      (q_head[i]),
      .full      (q_full[i]),
      .empty     (q_empty[i])
    );
  end

  // Route the addressed queue's status, head and error flag to the accept/compare logic
  always_comb begin
    exp_full_sel  = 1'b0;
    act_empty_sel = 1'b1;
    act_flag_sel  = 1'b0;
    head_sel      = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      if (exp_q == ID_W'(i)) begin
        exp_full_sel = q_full[i];
      end
      if (act_q == ID_W'(i)) begin
        act_empty_sel = q_empty[i];
        act_flag_sel  = err_flag_q[i];
        head_sel      = q_head[i];
      end
    end
  end

  // Full blocks a push even when the same queue pops; an actual beat waits for its expected beat
  assign exp_ready = !exp_full_sel && !clear;
  assign act_ready = !act_empty_sel && !clear;
  assign exp_acc   = exp_valid && exp_ready;
  assign act_acc   = act_valid && act_ready;
  assign beat_mis  = (act_ent != head_sel);
  assign idle      = &q_empty;

  // Compare result, per-queue error flags and transaction close counting
  always_comb begin
    err_flag_d    = err_flag_q;
    match_cnt_d   = match_cnt_q;
    err_cnt_d     = err_cnt_q;
    mismatch_d    = 1'b0;
    mismatch_id_d = mismatch_id_q;
    if (clear) begin
      err_flag_d    = '0;
      match_cnt_d   = '0;
      err_cnt_d     = '0;
      mismatch_id_d = '0;
    end else if (act_acc) begin
      if (beat_mis) begin
        mismatch_d    = 1'b1;
        mismatch_id_d = act_id;
      end
      for (int i = 0; i < NUM_Q; i++) begin
        if (act_q == ID_W'(i)) begin
          if (act_last) begin
            err_flag_d[i] = 1'b0;
          end else if (beat_mis) begin
            err_flag_d[i] = 1'b1;
          end
        end
      end
      if (act_last) begin
        if (act_flag_sel || beat_mis) begin
          err_cnt_d = cnt_inc(err_cnt_q);
        end else begin
          match_cnt_d = cnt_inc(match_cnt_q);
        end
      end
    end
  end

  // Stall watchdog: counts cycles with work outstanding but no actual beat accepted
  always_comb begin
    stall_d       = stall_q;
    timeout_d     = 1'b0;
    timeout_cnt_d = timeout_cnt_q;
    if (clear) begin
      stall_d       = '0;
      timeout_cnt_d = '0;
    end else if ((TIMEOUT == 0) || idle || act_acc) begin
      stall_d = '0;
    end else if (stall_q == STALL_LAST) begin
      stall_d       = '0;
      timeout_d     = 1'b1;
      timeout_cnt_d = cnt_inc(timeout_cnt_q);
    end else begin
      stall_d = stall_q + STALL_ONE;
    end
  end

  // Scoreboard state registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_flag_q    <= '0;
      match_cnt_q   <= '0;
      err_cnt_q     <= '0;
      timeout_cnt_q <= '0;
      mismatch_q    <= 1'b0;
      mismatch_id_q <= '0;
      timeout_q     <= 1'b0;
      stall_q       <= '0;
    end else begin
      err_flag_q    <= err_flag_d;
      match_cnt_q   <= match_cnt_d;
      err_cnt_q     <= err_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      mismatch_q    <= mismatch_d;
      mismatch_id_q <= mismatch_id_d;
      timeout_q     <= timeout_d;
      stall_q       <= stall_d;
    end
  end

  assign match_cnt   = match_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign timeout_cnt = timeout_cnt_q;
  assign mismatch    = mismatch_q;
  assign mismatch_id = mismatch_id_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_axi_beat_scoreboard.sv
// tb/tb_axi_beat_scoreboard.sv - self-checking bench for axi_beat_scoreboard
module tb_axi_beat_scoreboard;

  localparam int DW    = 32;
  localparam int IW    = 2;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int TMO   = 16;
  localparam int CMAX  = (1 << CW) - 1;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          clear, exp_valid, exp_last, act_valid, act_last;
  logic [IW-1:0] exp_id, act_id;
  logic [DW-1:0] exp_data, act_data;
  logic          exp_ready, act_ready, mismatch, timeout, idle;
  logic [IW-1:0] mismatch_id;
  logic [CW-1:0] match_cnt, err_cnt, timeout_cnt;

  logic          g_clear, g_exp_valid, g_exp_last, g_act_valid, g_act_last;
  logic [IW-1:0] g_exp_id, g_act_id;
  logic [DW-1:0] g_exp_data, g_act_data;
  logic          g_exp_ready, g_act_ready, g_mismatch, g_timeout, g_idle;
  logic [IW-1:0] g_mismatch_id;
  logic [CW-1:0] g_match_cnt, g_err_cnt, g_timeout_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW:0] mq [4][$];
  logic [DW:0] sl [4][$];

  always #5 aclk = ~aclk;

  axi_beat_scoreboard #(
    .DATA_W(DW), .ID_W(IW), .DEPTH(DEPTH), .CNT_W(CW), .TIMEOUT(TMO), .PER_ID(1)
  ) u_dut (
    .aclk(aclk), .aresetn(aresetn), .clear(clear),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_id(exp_id), .exp_data(exp_data), .exp_last(exp_last),
    .act_valid(act_valid), .act_ready(act_ready), .act_id(act_id), .act_data(act_data), .act_last(act_last),
    .match_cnt(match_cnt), .err_cnt(err_cnt), .timeout_cnt(timeout_cnt),
    .mismatch(mismatch), .mismatch_id(mismatch_id), .timeout(timeout), .idle(idle)
  );

  axi_beat_scoreboard #(
    .DATA_W(DW), .ID_W(IW), .DEPTH(DEPTH), .CNT_W(CW), .TIMEOUT(0), .PER_ID(0)
  ) u_dut_g (
    .aclk(aclk), .aresetn(aresetn), .clear(g_clear),
    .exp_valid(g_exp_valid), .exp_ready(g_exp_ready), .exp_id(g_exp_id), .exp_data(g_exp_data), .exp_last(g_exp_last),
    .act_valid(g_act_valid), .act_ready(g_act_ready), .act_id(g_act_id), .act_data(g_act_data), .act_last(g_act_last),
    .match_cnt(g_match_cnt), .err_cnt(g_err_cnt), .timeout_cnt(g_timeout_cnt),
    .mismatch(g_mismatch), .mismatch_id(g_mismatch_id), .timeout(g_timeout), .idle(g_idle)
  );

  task automatic push_exp(input logic [IW-1:0] id, input logic [DW-1:0] d, input logic l);
    int k;
    exp_valid = 1'b1; exp_id = id; exp_data = d; exp_last = l;
    for (k = 0; k < 40; k++) begin
      @(negedge aclk);
      if (exp_ready) break;
      @(posedge aclk); #1;
    end
    n_cmp++;
    if (k == 40) begin
      n_fail++; $display("FAIL exp_accept_wait: exp_ready stayed %b, required 1", exp_ready);
    end
    @(posedge aclk); #1;
    exp_valid = 1'b0;
  endtask

  task automatic push_act(input logic [IW-1:0] id, input logic [DW-1:0] d, input logic l);
    int k;
    act_valid = 1'b1; act_id = id; act_data = d; act_last = l;
    for (k = 0; k < 40; k++) begin
      @(negedge aclk);
      if (act_ready) break;
      @(posedge aclk); #1;
    end
    n_cmp++;
    if (k == 40) begin
      n_fail++; $display("FAIL act_accept_wait: act_ready stayed %b, required 1", act_ready);
    end
    @(posedge aclk); #1;
    act_valid = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    n_cmp++; if ({match_cnt, err_cnt, timeout_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_counters: got %h, required 0", {match_cnt, err_cnt, timeout_cnt}); end
    n_cmp++; if ({mismatch, timeout, mismatch_id} !== '0) begin
      n_fail++; $display("FAIL reset_pulses: got %b, required 0", {mismatch, timeout, mismatch_id}); end
    n_cmp++; if ({idle, exp_ready, act_ready} !== 3'b110) begin
      n_fail++; $display("FAIL reset_status: idle/exp_ready/act_ready got %b, required 110", {idle, exp_ready, act_ready}); end
    aresetn = 1'b1;
    @(posedge aclk); #1;
  endtask

  task automatic test_basic();
    logic [DW-1:0] a0, a1;
    a0 = $urandom; a1 = $urandom;
    push_exp(0, a0, 0);
    push_exp(0, a1, 1);
    push_act(0, a0, 0);
    n_cmp++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL basic_beat0: mismatch got %b, required 0", mismatch); end
    push_act(0, a1, 1);
    n_cmp++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL basic_beat1: mismatch got %b, required 0", mismatch); end
    n_cmp++; if ({match_cnt, err_cnt} !== {4'd1, 4'd0}) begin
      n_fail++; $display("FAIL basic_counts: match/err got %0d/%0d, required 1/0", match_cnt, err_cnt); end
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL basic_idle: got %b, required 1", idle); end
  endtask

  task automatic test_stall();
    logic [DW-1:0] d;
    d = $urandom;
    act_valid = 1'b1; act_id = 1; act_data = d; act_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      n_cmp++; if (act_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %b, required 0", act_ready); end
      @(posedge aclk); #1;
    end
    push_exp(1, d, 1);
    @(negedge aclk);
    n_cmp++; if (act_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release: got %b, required 1", act_ready); end
    @(posedge aclk); #1;
    act_valid = 1'b0;
    n_cmp++; if ({match_cnt, mismatch} !== {4'd2, 1'b0}) begin
      n_fail++; $display("FAIL stall_match: match/mismatch got %0d/%b, required 2/0", match_cnt, mismatch); end
  endtask

  task automatic test_interleave();
    logic [DW-1:0] b0, b1, c0, c1;
    b0 = $urandom; b1 = $urandom; c0 = $urandom; c1 = $urandom;
    push_exp(2, b0, 0); push_exp(3, c0, 0); push_exp(2, b1, 1); push_exp(3, c1, 1);
    push_act(2, b0, 0);
    push_act(3, c0, 0);
    n_cmp++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL inter_clean: mismatch got %b, required 0", mismatch); end
    push_act(3, c1 ^ 32'h1, 1);
    n_cmp++; if ({mismatch, mismatch_id} !== {1'b1, 2'd3}) begin
      n_fail++; $display("FAIL inter_pulse: mismatch/id got %b/%0d, required 1/3", mismatch, mismatch_id); end
    n_cmp++; if (err_cnt !== 4'd1) begin n_fail++; $display("FAIL inter_err: got %0d, required 1", err_cnt); end
    push_act(2, b1, 1);
    n_cmp++; if ({mismatch, mismatch_id, match_cnt, err_cnt} !== {1'b0, 2'd3, 4'd3, 4'd1}) begin
      n_fail++; $display("FAIL inter_id2: mismatch/id/match/err got %b/%0d/%0d/%0d, required 0/3/3/1",
                         mismatch, mismatch_id, match_cnt, err_cnt); end
  endtask

  task automatic test_full();
    logic [DW-1:0] base;
    base = $urandom & 32'hFFFF_FF00;
    for (int i = 0; i < 8; i++) push_exp(0, base + DW'(i), 1);
    exp_valid = 1'b1; exp_id = 0; exp_data = base + 8; exp_last = 1'b1;
    @(negedge aclk);
    n_cmp++; if (exp_ready !== 1'b0) begin n_fail++; $display("FAIL full_9th: exp_ready got %b, required 0", exp_ready); end
    @(posedge aclk); #1;
    act_valid = 1'b1; act_id = 0; act_data = base; act_last = 1'b1;
    @(negedge aclk);
    n_cmp++; if ({exp_ready, act_ready} !== 2'b01) begin
      n_fail++; $display("FAIL full_pop_no_push: exp/act ready got %b, required 01", {exp_ready, act_ready}); end
    @(posedge aclk); #1;
    act_data = base + 1;
    @(negedge aclk);
    n_cmp++; if ({exp_ready, act_ready} !== 2'b11) begin
      n_fail++; $display("FAIL full_push_pop: exp/act ready got %b, required 11", {exp_ready, act_ready}); end
    @(posedge aclk); #1;
    act_valid = 1'b0; exp_data = base + 9;
    @(negedge aclk);
    n_cmp++; if (exp_ready !== 1'b1) begin n_fail++; $display("FAIL full_count7: exp_ready got %b, required 1", exp_ready); end
    @(posedge aclk); #1;
    exp_data = base + 10;
    @(negedge aclk);
    n_cmp++; if (exp_ready !== 1'b0) begin n_fail++; $display("FAIL full_again: exp_ready got %b, required 0", exp_ready); end
    @(posedge aclk); #1;
    exp_valid = 1'b0;
    for (int i = 2; i < 10; i++) push_act(0, base + DW'(i), 1);
    n_cmp++; if ({match_cnt, err_cnt, idle} !== {4'd13, 4'd1, 1'b1}) begin
      n_fail++; $display("FAIL full_drain: match/err/idle got %0d/%0d/%b, required 13/1/1", match_cnt, err_cnt, idle); end
  endtask

  task automatic test_timeout();
    logic [DW-1:0] d;
    clear = 1'b1;
    @(posedge aclk); #1;
    clear = 1'b0;
    n_cmp++; if ({match_cnt, err_cnt, timeout_cnt, idle} !== {12'd0, 1'b1}) begin
      n_fail++; $display("FAIL clear_state: counters/idle got %h/%b, required 000/1", {match_cnt, err_cnt, timeout_cnt}, idle); end
    d = $urandom;
    push_exp(1, d, 1);
    for (int k = 1; k <= 40; k++) begin
      @(posedge aclk); #1;
      n_cmp++; if (timeout !== ((k == 16) || (k == 32))) begin
        n_fail++; $display("FAIL timeout_pulse: cycle %0d got %b, required %b", k, timeout, (k == 16) || (k == 32)); end
      if (k == 16) begin
        n_cmp++; if (timeout_cnt !== 4'd1) begin n_fail++; $display("FAIL timeout_cnt1: got %0d, required 1", timeout_cnt); end
      end
    end
    n_cmp++; if (timeout_cnt !== 4'd2) begin n_fail++; $display("FAIL timeout_cnt2: got %0d, required 2", timeout_cnt); end
    push_act(1, d, 1);
    clear = 1'b1;
    @(posedge aclk); #1;
    clear = 1'b0;
  endtask

  task automatic test_clear_midburst();
    logic [DW-1:0] p0, q0, q1, r0, s0;
    p0 = $urandom; q0 = $urandom; q1 = $urandom; r0 = $urandom; s0 = $urandom;
    push_exp(0, p0, 1); push_act(0, p0, 1);
    push_exp(2, q0, 0); push_exp(2, q1, 1);
    push_act(2, q0 ^ 32'h2, 0);
    push_exp(3, r0, 0);
    n_cmp++; if ({match_cnt, err_cnt, mismatch} !== {4'd1, 4'd0, 1'b0}) begin
      n_fail++; $display("FAIL clr_pre: match/err/mismatch got %0d/%0d/%b, required 1/0/0", match_cnt, err_cnt, mismatch); end
    clear = 1'b1;
    exp_valid = 1'b1; exp_id = 3; exp_data = $urandom; exp_last = 1'b1;
    act_valid = 1'b1; act_id = 2; act_data = q1; act_last = 1'b1;
    @(negedge aclk);
    n_cmp++; if ({exp_ready, act_ready} !== 2'b00) begin
      n_fail++; $display("FAIL clr_ready: exp/act ready got %b, required 00", {exp_ready, act_ready}); end
    @(posedge aclk); #1;
    clear = 1'b0; exp_valid = 1'b0; act_valid = 1'b0;
    n_cmp++; if ({match_cnt, err_cnt, idle, mismatch} !== {8'd0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL clr_state: match/err/idle/mismatch got %0d/%0d/%b/%b, required 0/0/1/0",
                         match_cnt, err_cnt, idle, mismatch); end
    push_exp(2, s0, 1); push_act(2, s0, 1);
    n_cmp++; if ({match_cnt, err_cnt} !== {4'd1, 4'd0}) begin
      n_fail++; $display("FAIL clr_flag: match/err got %0d/%0d, required 1/0", match_cnt, err_cnt); end
  endtask

  task automatic test_reset_midburst();
    logic [DW-1:0] t0, t1, u;
    t0 = $urandom; t1 = $urandom; u = $urandom;
    push_exp(1, t0, 0); push_exp(1, t1, 1); push_act(1, t0, 0);
    act_id = 1;
    #2 aresetn = 1'b0;
    #1;
    n_cmp++; if ({match_cnt, err_cnt, timeout_cnt} !== '0) begin
      n_fail++; $display("FAIL rst_mid_counters: got %h, required 0", {match_cnt, err_cnt, timeout_cnt}); end
    n_cmp++; if ({idle, exp_ready, act_ready} !== 3'b110) begin
      n_fail++; $display("FAIL rst_mid_status: idle/exp/act got %b, required 110", {idle, exp_ready, act_ready}); end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    push_exp(1, u, 1); push_act(1, u, 1);
    n_cmp++; if ({match_cnt, err_cnt, mismatch} !== {4'd1, 4'd0, 1'b0}) begin
      n_fail++; $display("FAIL rst_mid_after: match/err/mismatch got %0d/%0d/%b, required 1/0/0", match_cnt, err_cnt, mismatch); end
  endtask

  task automatic test_global();
    logic [DW-1:0] x, y;
    x = $urandom; y = $urandom;
    g_exp_valid = 1'b1; g_exp_id = 1; g_exp_data = x; g_exp_last = 1'b1;
    @(negedge aclk);
    n_cmp++; if (g_exp_ready !== 1'b1) begin n_fail++; $display("FAIL glob_exp_ready: got %b, required 1", g_exp_ready); end
    @(posedge aclk); #1;
    g_exp_valid = 1'b0;
    g_act_valid = 1'b1; g_act_id = 2; g_act_data = x; g_act_last = 1'b1;
    @(negedge aclk);
    n_cmp++; if (g_act_ready !== 1'b1) begin n_fail++; $display("FAIL glob_act_ready: got %b, required 1", g_act_ready); end
    @(posedge aclk); #1;
    g_act_valid = 1'b0;
    n_cmp++; if ({g_mismatch, g_mismatch_id, g_err_cnt, g_match_cnt} !== {1'b1, 2'd2, 4'd1, 4'd0}) begin
      n_fail++; $display("FAIL glob_wrong_id: mismatch/id/err/match got %b/%0d/%0d/%0d, required 1/2/1/0",
                         g_mismatch, g_mismatch_id, g_err_cnt, g_match_cnt); end
    g_exp_valid = 1'b1; g_exp_id = 3; g_exp_data = y;
    @(posedge aclk); #1;
    g_exp_valid = 1'b0;
    g_act_valid = 1'b1; g_act_id = 3; g_act_data = y; g_act_last = 1'b1;
    @(posedge aclk); #1;
    g_act_valid = 1'b0;
    n_cmp++; if ({g_mismatch, g_match_cnt, g_err_cnt, g_idle} !== {1'b0, 4'd1, 4'd1, 1'b1}) begin
      n_fail++; $display("FAIL glob_match: mismatch/match/err/idle got %b/%0d/%0d/%b, required 0/1/1/1",
                         g_mismatch, g_match_cnt, g_err_cnt, g_idle); end
  endtask

  task automatic test_random();
    int m_match, m_err, m_tcnt, stall, aid;
    bit m_mis, m_tmo, e_rdy, a_rdy, e_acc, a_acc, m_idle, mis;
    bit flag [4];
    logic [IW-1:0] m_mid;
    logic [DW:0] ent, head;
    aresetn = 1'b0;
    exp_valid = 1'b0; act_valid = 1'b0; clear = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    for (int q = 0; q < 4; q++) begin mq[q].delete(); sl[q].delete(); flag[q] = 1'b0; end
    m_match = 0; m_err = 0; m_tcnt = 0; stall = 0; m_mis = 1'b0; m_tmo = 1'b0; m_mid = '0;
    for (int cyc = 0; cyc <= 1500; cyc++) begin
      n_cmp++; if ({mismatch, timeout} !== {m_mis, m_tmo}) begin
        n_fail++; $display("FAIL rnd_pulse: cyc %0d mismatch/timeout got %b%b, required %b%b", cyc, mismatch, timeout, m_mis, m_tmo); end
      n_cmp++; if (mismatch_id !== m_mid) begin
        n_fail++; $display("FAIL rnd_mid: cyc %0d got %0d, required %0d", cyc, mismatch_id, m_mid); end
      n_cmp++; if ({match_cnt, err_cnt, timeout_cnt} !== {CW'(m_match), CW'(m_err), CW'(m_tcnt)}) begin
        n_fail++; $display("FAIL rnd_cnt: cyc %0d match/err/tmo got %0d/%0d/%0d, required %0d/%0d/%0d",
                           cyc, match_cnt, err_cnt, timeout_cnt, m_match, m_err, m_tcnt); end
      if (cyc == 1500) break;
      exp_valid = ($urandom_range(0, 1) == 1);
      exp_id    = IW'($urandom_range(0, 3));
      exp_data  = $urandom;
      exp_last  = ($urandom_range(0, 2) == 0);
      aid = $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0) begin
        for (int k = 0; k < 4; k++) begin
          if (sl[(aid + k) % 4].size() > 0) begin aid = (aid + k) % 4; break; end
        end
      end
      act_valid = ($urandom_range(0, 3) != 0);
      act_id    = IW'(aid);
      if (sl[aid].size() > 0) {act_data, act_last} = sl[aid][0];
      else begin act_data = $urandom; act_last = $urandom_range(0, 1); end
      @(negedge aclk);
      m_idle = (mq[0].size() == 0) && (mq[1].size() == 0) && (mq[2].size() == 0) && (mq[3].size() == 0);
      e_rdy = (mq[exp_id].size() < DEPTH);
      a_rdy = (mq[act_id].size() > 0);
      n_cmp++; if ({exp_ready, act_ready, idle} !== {e_rdy, a_rdy, m_idle}) begin
        n_fail++; $display("FAIL rnd_ready: cyc %0d exp/act/idle got %b%b%b, required %b%b%b",
                           cyc, exp_ready, act_ready, idle, e_rdy, a_rdy, m_idle); end
      e_acc = exp_valid && e_rdy;
      a_acc = act_valid && a_rdy;
      m_mis = 1'b0; m_tmo = 1'b0;
      if (a_acc) begin
        head = mq[act_id].pop_front();
        void'(sl[act_id].pop_front());
        mis = ({act_data, act_last} != head);
        if (mis) begin m_mis = 1'b1; m_mid = act_id; end
        if (act_last) begin
          if (flag[act_id] || mis) m_err = (m_err < CMAX) ? m_err + 1 : CMAX;
          else m_match = (m_match < CMAX) ? m_match + 1 : CMAX;
          flag[act_id] = 1'b0;
        end else if (mis) flag[act_id] = 1'b1;
      end
      if (e_acc) begin
        ent = {exp_data, exp_last};
        mq[exp_id].push_back(ent);
        if ($urandom_range(0, 7) == 0) ent[$urandom_range(0, DW)] ^= 1'b1;
        sl[exp_id].push_back(ent);
      end
      if (m_idle || a_acc) stall = 0;
      else begin
        stall++;
        if (stall == TMO) begin stall = 0; m_tmo = 1'b1; m_tcnt = (m_tcnt < CMAX) ? m_tcnt + 1 : CMAX; end
      end
      @(posedge aclk); #1;
    end
    exp_valid = 1'b0; act_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required finish before 300000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear = 1'b0; exp_valid = 1'b0; exp_id = '0; exp_data = '0; exp_last = 1'b0;
    act_valid = 1'b0; act_id = '0; act_data = '0; act_last = 1'b0;
    g_clear = 1'b0; g_exp_valid = 1'b0; g_exp_id = '0; g_exp_data = '0; g_exp_last = 1'b0;
    g_act_valid = 1'b0; g_act_id = '0; g_act_data = '0; g_act_last = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_interleave();
    test_full();
    test_timeout();
    test_clear_midburst();
    test_reset_midburst();
    test_global();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
